// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcodes, flag bit positions and the writeback entry layout.
package fpu_pkg;

    localparam logic [6:0] FADD_S   = 7'b0000000;
    localparam logic [6:0] FSUB_S   = 7'b0000100;
    localparam logic [6:0] FADD_D   = 7'b0000001;
    localparam logic [6:0] FSUB_D   = 7'b0000101;
    localparam logic [6:0] FCVT_D_S = 7'b0100001;
    localparam logic [6:0] FCVT_D_W = 7'b1101001;
    localparam logic [6:0] FCMP_S   = 7'b1010000;
    localparam logic [6:0] FCMP_D   = 7'b1010001;
    localparam logic [6:0] FCVT_W_S = 7'b1100000;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

    // One buffered writeback entry, already formatted for its register file.
    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
        logic        is_int;
        logic [4:0]  flags;
    } wb_entry_t;

    localparam int unsigned WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/fpu_wb_stage_if.sv
// Handshake bundle between the FPU, the writeback stage and the register files.
interface fpu_wb_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_func7;
    logic [4:0]  in_rd;
    logic [63:0] in_result;
    logic        in_flag_invalid;
    logic        in_flag_divbyzero;
    logic        in_flag_overflow;
    logic        in_flag_underflow;
    logic        in_flag_inexact;
    logic        in_flag_cmp;

    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [63:0] out_data;
    logic        out_is_int;

    // Environment side: FPU producer and register-file consumer.
    modport master (
        output in_valid, in_func7, in_rd, in_result,
               in_flag_invalid, in_flag_divbyzero, in_flag_overflow,
               in_flag_underflow, in_flag_inexact, in_flag_cmp,
        input  in_ready,
        input  out_valid, out_rd, out_data, out_is_int,
        output out_ready
    );

    // Writeback stage side.
    modport slave (
        input  in_valid, in_func7, in_rd, in_result,
               in_flag_invalid, in_flag_divbyzero, in_flag_overflow,
               in_flag_underflow, in_flag_inexact, in_flag_cmp,
        output in_ready,
        output out_valid, out_rd, out_data, out_is_int,
        input  out_ready
    );

endinterface

// File: rtl/fpu_wb_fifo.sv
// In-order FIFO holding formatted writeback entries; flush empties it in one cycle.
module fpu_wb_fifo #(
    parameter int unsigned WIDTH = 75,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (cnt != DEPTH_C) && !flush;
    assign pop_ok  = pop && (cnt != '0);
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // Pointer/count bookkeeping and storage write; power-of-two DEPTH lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fpu_wb_stage.sv
// FPU writeback stage: formats results per opcode, buffers them in order and
// accumulates retired exception flags into the sticky fflags CSR field.
module fpu_wb_stage
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_wb_stage_if.slave        wb,
    input  logic                 flush,
    input  logic                 csr_fflags_we,
    input  logic [4:0]           csr_fflags_wdata,
    output logic [4:0]           fflags
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    wb_entry_t     push_entry;
    wb_entry_t     head;
    logic [CW-1:0] count;
    logic          retire;
    logic [4:0]    retire_flags;

    // Format the incoming FPU result for its destination register file.
    always_comb begin
        push_entry                = '0;
        push_entry.rd             = wb.in_rd;
        push_entry.data           = wb.in_result;
        push_entry.is_int         = 1'b0;
        push_entry.flags[FLAG_NV] = wb.in_flag_invalid;
        push_entry.flags[FLAG_DZ] = wb.in_flag_divbyzero;
        push_entry.flags[FLAG_OF] = wb.in_flag_overflow;
        push_entry.flags[FLAG_UF] = wb.in_flag_underflow;
        push_entry.flags[FLAG_NX] = wb.in_flag_inexact;
        case (wb.in_func7)
            FADD_S, FSUB_S: begin
                push_entry.data = {NANBOX_HI, wb.in_result[31:0]};
            end
            FADD_D, FSUB_D, FCVT_D_S, FCVT_D_W: begin
                push_entry.data = wb.in_result;
            end
            FCMP_S, FCMP_D: begin
                push_entry.data   = {63'b0, wb.in_flag_cmp};
                push_entry.is_int = 1'b1;
            end
            FCVT_W_S: begin
                push_entry.data   = {{32{wb.in_result[31]}}, wb.in_result[31:0]};
                push_entry.is_int = 1'b1;
            end
            default: ;
        endcase
    end

    fpu_wb_fifo #(
        .WIDTH (WB_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (wb.in_valid && wb.in_ready),
        .wdata (push_entry),
        .pop   (retire),
        .rdata (head),
        .count (count)
    );

    assign wb.in_ready   = (count != DEPTH_C);
    assign wb.out_valid  = (count != '0);
    assign wb.out_rd     = head.rd;
    assign wb.out_data   = head.data;
    assign wb.out_is_int = head.is_int;

    assign retire       = wb.out_valid && wb.out_ready;
    assign retire_flags = retire ? head.flags : 5'b0;

    // Sticky flags: a CSR write lands first, retiring flags are ORed on top.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fflags <= '0;
        end else begin
            fflags <= (csr_fflags_we ? csr_fflags_wdata : fflags) | retire_flags;
        end
    end

endmodule

// File: doc/fpu_wb_stage.md
# fpu_wb_stage

Writeback stage directly downstream of the combinational FPU top. It captures each FPU result and flag set on a valid/ready handshake and formats the data for its destination register file: NaN-boxing for FP32, sign-extension for INT32, and a 0/1 word for compares. Results are buffered in a small in-order FIFO and retired to the register-file write port. On retirement, the block accumulates the sticky IEEE exception flags into the `fflags` CSR field.

## Interface
Parameters:
- `DEPTH`, default 2: FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  FPU output holds a valid operation.
- `in_ready`  out  1  entry accepted this cycle when `in_valid && in_ready`.
- `in_func7`  in  7  opcode of the operation; selects formatting.
- `in_rd`  in  5  destination register tag, passed through.
- `in_result`  in  64  FPU `result_out`.
- `in_flag_invalid`, `in_flag_divbyzero`, `in_flag_overflow`, `in_flag_underflow`, `in_flag_inexact`  in  1 each  FPU status flags.
- `in_flag_cmp`  in  1  compare outcome.
- `flush`  in  1  discard all buffered entries.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  register file accepts the head entry.
- `out_rd`  out  5  head destination tag.
- `out_data`  out  64  head formatted data.
- `out_is_int`  out  1  1 means the integer register file, 0 means the FP register file.
- `csr_fflags_we`  in  1  CSR write strobe.
- `csr_fflags_wdata`  in  5  CSR write data.
- `fflags`  out  5  sticky flags, ordered {NV,DZ,OF,UF,NX} in bits [4:0].

## Operation
Formatting is applied at push time, and the formatted value is what gets stored:
- FADD_S `0000000`, FSUB_S `0000100`: data = {32'hFFFF_FFFF, result[31:0]}; is_int = 0.
- FADD_D `0000001`, FSUB_D `0000101`, FCVT_D_S `0100001`, FCVT_D_W `1101001`: data = result; is_int = 0.
- FCMP_S `1010000`, FCMP_D `1010001`: data = {63'b0, in_flag_cmp}; is_int = 1.
- FCVT_W_S `1100000`: data = {{32{result[31]}}, result[31:0]}; is_int = 1.
- Any other opcode: data = result; is_int = 0; flags are stored unmodified.

Each entry holds {rd, data, is_int, flags[4:0]}. The flags are packed as {invalid, divbyzero, overflow, underflow, inexact}.

FIFO behaviour:
- Ordering is strict in-order.
- `count` ranges 0..DEPTH; read and write pointers wrap modulo DEPTH.
- `in_ready = (count != DEPTH)`. It is derived from state only and does not depend on `out_ready`.
- `out_valid = (count != 0)`. The `out_*` signals present the head entry.

Sticky flags:
- The update is `fflags_next = (csr_fflags_we ? csr_fflags_wdata : fflags) | retire_flags`.
- `retire_flags` is the head's flags when `out_valid && out_ready`, and 0 otherwise.
- In the same cycle, a CSR write is applied first and the retiring flags are ORed on top.

Flush:
- The next state is `count = 0` with both pointers at 0.
- A push in the flush cycle is discarded.
- A retire handshake in the flush cycle still counts: it ORs into `fflags`.

## Timing
- Reset at a clock edge with `rst_n` = 0 produces:
  - `count` = 0 and both pointers = 0, so `out_valid` = 0 and `in_ready` = 1.
  - All storage cleared, so `out_rd` = 0, `out_data` = 0, `out_is_int` = 0.
  - `fflags` = 0.
- Reset in the middle of a burst drops every entry without any flag accumulation.
- Latency is 1 cycle: a push at edge N makes `out_valid` high after edge N if the FIFO was empty.
- Throughput is one entry per cycle with `out_ready` held high.
- When full, `in_ready` = 0 even if a pop occurs in that cycle. Throughput therefore drops only when the FIFO is full.
- Push and pop in the same cycle with 0 < count < DEPTH leave `count` unchanged.
- A push and a pop while empty cannot both occur, because `out_valid` = 0 when empty.
- `out_*` signals must be held stable while `out_valid && !out_ready`.
- `fflags` updates on the edge after the retire handshake or the CSR write.

## Structure
- Shared package `fpu_pkg` holds:
  - opcode localparams (FADD_S … FCVT_D_W);
  - flag bit indices FLAG_NV=4 … FLAG_NX=0;
  - constant NANBOX_HI = 32'hFFFF_FFFF.
- The FIFO is one sub-module, `fpu_wb_fifo`:
  - parameterised by width (75 bits) and `DEPTH`;
  - provides push/pop, count, and flush.
- Formatting logic and the `fflags` register live in the top of this block.

## Test plan
- **Single FP32 add:** push FADD_S with result 64'h0000_0000_3F80_0000, inexact=1, rd=3.
  - Next cycle: `out_data` = 64'hFFFF_FFFF_3F80_0000, `out_is_int` = 0, `out_rd` = 3.
  - After retire: `fflags` = 5'b00001.
- **Convert and compare formatting:**
  - FCVT_W_S with result[31:0] = 32'h8000_0001 → `out_data` = 64'hFFFF_FFFF_8000_0001, `out_is_int` = 1.
  - FCMP_D with cmp=1 → `out_data` = 64'h1, `out_is_int` = 1.
- **Backpressure:** hold `out_ready` = 0 and push 3 entries with `DEPTH` = 2.
  - The third push stalls with `in_ready` = 0, and `out_*` stays stable.
  - Release `out_ready`: entries retire in order A, B, then the third entry C is accepted.
- **CSR/retire collision:** with `fflags` = 5'b10000, write `csr_fflags_wdata` = 0 in the same cycle as retiring an entry with overflow=1.
  - Required: `fflags` = 5'b00100.
- **Flush:** two entries buffered and flush asserted together with a push and a retire of the head.
  - Required: retired head flags ORed into `fflags`, then `count` = 0, `out_valid` = 0, and the pushed entry is lost.
- **Reset mid-burst:** assert `rst_n` = 0 for one cycle with 2 entries buffered and `fflags` nonzero.
  - Required: `out_valid` = 0, `in_ready` = 1, `fflags` = 0, and all `out_*` = 0.
